io_uart: RTL and testbench



---
 rtl/io_defs.sv | 18 +
 rtl/io_fifo.sv | 41 ++++
 rtl/io_uart.sv | 140 ++++++++++++++
 tb/tb_io_uart.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/io_defs.sv
// Shared definitions for the IO-window UART: register offsets, STATUS bit
// positions and the 2-bit FSM state encodings used by both serial engines.
package io_defs;
  localparam logic [15:0] IO_BASE     = 16'hBFD0;
  localparam logic [15:0] UART_DATA   = 16'h0000;
  localparam logic [15:0] UART_STATUS = 16'h0004;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is dropped even
// when a pop happens in the same cycle.
module io_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout    = mem_q[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serial shifter, RX with a single
// holding register, overrun/frame-error flags cleared by STATUS reads.
module io_uart
  import io_defs::*;
#(
  parameter int DIV      = 434,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_ce,
  input  logic        io_we,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_din,
  output logic [31:0] io_dout,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);
  localparam logic [15:0] DIV_W  = 16'(DIV);
  localparam logic [15:0] HALF_W = 16'(DIV / 2);

  logic [15:0] off;
  logic        wr_data, rd_data, rd_stat, unused_bits;
  assign off         = io_addr[15:0];
  assign wr_data     = io_ce &&  io_we && (off == UART_DATA);
  assign rd_data     = io_ce && !io_we && (off == UART_DATA);
  assign rd_stat     = io_ce && !io_we && (off == UART_STATUS);
  assign unused_bits = ^{io_addr[31:16], io_din[31:8]};

  logic [7:0] fifo_dout;
  logic       fifo_full, fifo_empty, tx_pop;

  io_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_txf (
    .clk(clk), .rst_n(rst_n), .push(wr_data), .pop(tx_pop), .din(io_din[7:0]),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  // TX engine; each state lasts while the counter runs from DIV down to 1
  logic [1:0]  tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      S_IDLE: if (!fifo_empty) begin
        tx_pop = 1'b1; tx_sh_d = fifo_dout; tx_cnt_d = DIV_W; tx_st_d = S_START;
      end
      S_START: if (tx_cnt_q == 16'd1) begin
        tx_cnt_d = DIV_W; tx_bit_d = 3'd0; tx_st_d = S_DATA;
      end else tx_cnt_d = tx_cnt_q - 16'd1;
      S_DATA: if (tx_cnt_q == 16'd1) begin
        tx_cnt_d = DIV_W; tx_sh_d = {1'b0, tx_sh_q[7:1]}; tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
      end else tx_cnt_d = tx_cnt_q - 16'd1;
      default: if (tx_cnt_q == 16'd1) begin
        tx_cnt_d = '0; tx_st_d = S_IDLE;
      end else tx_cnt_d = tx_cnt_q - 16'd1;
    endcase
  end

  // Registered line output trails the state by one cycle (start bit at write+2)
  assign txd_d = (tx_st_q == S_START) ? 1'b0 :
                 (tx_st_q == S_DATA)  ? tx_sh_q[0] : 1'b1;

  // RX engine behind a 2-flop synchronizer; sync flops reset to idle-high
  logic        rxd_m_q, rxd_s_q, rxd_p_q;
  logic [1:0]  rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_data_q;
  logic        rx_ok, rx_bad;
  logic        rx_valid_q, overrun_q, frame_err_q;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_ok    = 1'b0;
    rx_bad   = 1'b0;
    case (rx_st_q)
      S_IDLE: if (rxd_p_q && !rxd_s_q) begin
        rx_cnt_d = HALF_W; rx_st_d = S_START;
      end
      S_START: if (rx_cnt_q == 16'd1) begin
        if (rxd_s_q) begin rx_cnt_d = '0; rx_st_d = S_IDLE; end
        else begin rx_cnt_d = DIV_W; rx_bit_d = 3'd0; rx_st_d = S_DATA; end
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      S_DATA: if (rx_cnt_q == 16'd1) begin
        rx_cnt_d = DIV_W; rx_sh_d = {rxd_s_q, rx_sh_q[7:1]}; rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      default: if (rx_cnt_q == 16'd1) begin
        rx_cnt_d = '0; rx_st_d = S_IDLE; rx_ok = rxd_s_q; rx_bad = !rxd_s_q;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0; txd_q <= 1'b1;
      rxd_m_q <= 1'b1; rxd_s_q <= 1'b1; rxd_p_q <= 1'b1;
      rx_st_q <= S_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0; rx_data_q <= '0;
      rx_valid_q <= 1'b0; overrun_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
      txd_q   <= txd_d;
      rxd_m_q <= uart_rxd; rxd_s_q <= rxd_m_q; rxd_p_q <= rxd_s_q;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      if (rx_ok) rx_data_q <= rx_sh_q;
      // A completing byte beats a same-edge CPU pop; that race is not an overrun
      rx_valid_q  <= rx_ok ? 1'b1 : (rd_data ? 1'b0 : rx_valid_q);
      overrun_q   <= (rx_ok && rx_valid_q && !rd_data) ? 1'b1 : (rd_stat ? 1'b0 : overrun_q);
      frame_err_q <= rx_bad ? 1'b1 : (rd_stat ? 1'b0 : frame_err_q);
    end
  end

  always_comb begin
    io_dout = '0;
    if (rst_n && rd_data) io_dout = {24'b0, rx_data_q};
    else if (rst_n && rd_stat) begin
      io_dout[ST_TX_FULL]   = fifo_full;
      io_dout[ST_TX_EMPTY]  = fifo_empty && (tx_st_q == S_IDLE);
      io_dout[ST_RX_VALID]  = rx_valid_q;
      io_dout[ST_OVERRUN]   = overrun_q;
      io_dout[ST_FRAME_ERR] = frame_err_q;
    end
  end

  assign uart_txd = txd_q;
  assign irq      = rx_valid_q;
endmodule

// File: tb/tb_io_uart.sv
// Bench for io_uart: TX frames decoded by a line monitor against a scoreboard
// queue; RX bytes queued as frames are driven and checked on DATA reads.
module tb_io_uart;
  import io_defs::*;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_DATA = {IO_BASE, UART_DATA};
  localparam logic [31:0] A_STAT = {IO_BASE, UART_STATUS};
  localparam logic [31:0] A_BAD  = {IO_BASE, 16'h0008};

  logic        clk = 1'b0, rst_n = 1'b0, io_ce = 1'b0, io_we = 1'b0, uart_rxd = 1'b1;
  logic [31:0] io_addr = '0, io_din = '0;
  logic [31:0] io_dout;
  logic        uart_txd, irq;

  int   n_cmp = 0, n_bad = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_rx = 8'h00;
  logic mon_en = 1'b0, mon_busy = 1'b0;

  always #5 clk = ~clk;

  io_uart #(.DIV(DIV), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .io_ce(io_ce), .io_we(io_we), .io_addr(io_addr),
    .io_din(io_din), .io_dout(io_dout), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq)
  );

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); io_ce = 1'b1; io_we = 1'b1; io_addr = a; io_din = d;
    @(posedge clk); #1; io_ce = 1'b0; io_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); io_ce = 1'b1; io_we = 1'b0; io_addr = a;
    #1 d = io_dout;
    @(posedge clk); #1; io_ce = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk); uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_rxd = b[i]; repeat (DIV) @(negedge clk); end
    uart_rxd = stop; repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1; repeat (2*DIV) @(negedge clk);
  endtask

  task automatic wait_tx_drain(input int budget);
    int k = 0;
    while ((tx_q.size() != 0 || mon_busy) && k < budget) begin @(negedge clk); k++; end
    n_cmp++;
    if (k >= budget) begin n_bad++; $display("FAIL tx_drain: timeout, %0d bytes left, want 0", tx_q.size()); end
  endtask

  // TX line monitor: samples each bit near its centre
  initial begin : tx_mon
    logic [7:0] b, e;
    forever begin
      @(negedge clk);
      if (mon_en && uart_txd === 1'b0) begin
        mon_busy = 1'b1;
        repeat (DIV/2) @(negedge clk);
        n_cmp++;
        if (uart_txd !== 1'b0) begin n_bad++; $display("FAIL tx_start: got %b want 0", uart_txd); end
        for (int i = 0; i < 8; i++) begin repeat (DIV) @(negedge clk); b[i] = uart_txd; end
        repeat (DIV) @(negedge clk);
        n_cmp++;
        if (uart_txd !== 1'b1) begin n_bad++; $display("FAIL tx_stop: got %b want 1", uart_txd); end
        n_cmp++;
        if (tx_q.size() == 0) begin n_bad++; $display("FAIL tx_byte: got %h want none", b); end
        else begin
          e = tx_q.pop_front();
          if (b !== e) begin n_bad++; $display("FAIL tx_byte: got %h want %h", b, e); end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; uart_rxd = 1'b1; io_ce = 1'b1; io_we = 1'b0; io_addr = A_STAT;
    repeat (3) @(negedge clk); #1;
    n_cmp++; if (uart_txd !== 1'b1) begin n_bad++; $display("FAIL rst_txd: got %b want 1", uart_txd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_cmp++; if (io_dout !== 32'h0) begin n_bad++; $display("FAIL rst_dout: got %h want 0", io_dout); end
    io_ce = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL rst_status: got %h want 00000002", d); end
  endtask

  task automatic test_tx_single();
    logic [31:0] d;
    mon_en = 1'b1;
    tx_q.push_back(8'hA5);
    wr(A_DATA, 32'h0000_00A5);
    @(posedge clk); #1;
    n_cmp++; if (uart_txd !== 1'b1) begin n_bad++; $display("FAIL tx_lat_n1: got %b want 1", uart_txd); end
    @(posedge clk); #1;
    n_cmp++; if (uart_txd !== 1'b0) begin n_bad++; $display("FAIL tx_lat_n2: got %b want 0", uart_txd); end
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL tx_busy_status: got %h want 00000000", d); end
    wait_tx_drain(500);
    repeat (2) @(negedge clk);
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL tx_done_status: got %h want 00000002", d); end
  endtask

  task automatic test_tx_full();
    logic [31:0] d;
    for (int v = 8'h11; v <= 8'h16; v++) begin
      if (v <= 8'h15) tx_q.push_back(8'(v));
      wr(A_DATA, 32'(v));
    end
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL tx_full_status: got %h want 00000001", d); end
    wait_tx_drain(2000);
    repeat (2) @(negedge clk);
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL tx_full_drained: got %h want 00000002", d); end
  endtask

  task automatic test_rx_single();
    logic [31:0] d;
    logic [7:0]  e;
    rx_q.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rx_irq_set: got %b want 1", irq); end
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL rx_status: got %h want 00000006", d); end
    rd(A_DATA, d);
    e = rx_q.pop_front(); last_rx = e;
    n_cmp++; if (d !== {24'b0, e}) begin n_bad++; $display("FAIL rx_data: got %h want %h", d, {24'b0, e}); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rx_irq_clr: got %b want 0", irq); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  e;
    rx_q.push_back(8'h01); rx_frame(8'h01, 1'b1);
    rx_q.push_back(8'h02); rx_frame(8'h02, 1'b1);
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'hE) begin n_bad++; $display("FAIL ovr_status: got %h want 0000000e", d); end
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL ovr_status_clr: got %h want 00000006", d); end
    rd(A_DATA, d);
    e = rx_q[$]; rx_q.delete(); last_rx = e;
    n_cmp++; if (d !== {24'b0, e}) begin n_bad++; $display("FAIL ovr_data: got %h want %h", d, {24'b0, e}); end
    rx_frame(8'h55, 1'b0);
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h12) begin n_bad++; $display("FAIL ferr_status: got %h want 00000012", d); end
    rd(A_DATA, d);
    n_cmp++; if (d !== {24'b0, last_rx}) begin n_bad++; $display("FAIL ferr_data: got %h want %h", d, {24'b0, last_rx}); end
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL ferr_status_clr: got %h want 00000002", d); end
  endtask

  task automatic test_glitch_decode();
    logic [31:0] d;
    bit          moved = 1'b0;
    @(negedge clk); uart_rxd = 1'b0;
    @(negedge clk); uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL glitch_irq: got %b want 0", irq); end
    wr(A_BAD, 32'h0000_00FF);
    rd(A_BAD, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL bad_read: got %h want 0", d); end
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (uart_txd !== 1'b1) moved = 1'b1; end
    n_cmp++; if (moved) begin n_bad++; $display("FAIL bad_write_tx: got activity want idle"); end
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL glitch_status: got %h want 00000002", d); end
    @(negedge clk); io_ce = 1'b0; io_we = 1'b0; io_addr = A_DATA; #1;
    n_cmp++; if (io_dout !== 32'h0) begin n_bad++; $display("FAIL noce_read: got %h want 0", io_dout); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d;
    bit          moved = 1'b0;
    mon_en = 1'b0;
    wr(A_DATA, 32'h0000_0000);
    repeat (6) @(negedge clk);
    n_cmp++; if (uart_txd !== 1'b0) begin n_bad++; $display("FAIL midtx_low: got %b want 0", uart_txd); end
    rst_n = 1'b0; #1;
    n_cmp++; if (uart_txd !== 1'b1) begin n_bad++; $display("FAIL midtx_async: got %b want 1", uart_txd); end
    @(negedge clk); rst_n = 1'b1;
    rd(A_STAT, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL midtx_status: got %h want 00000002", d); end
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (uart_txd !== 1'b1) moved = 1'b1; end
    n_cmp++; if (moved) begin n_bad++; $display("FAIL midtx_flushed: got activity want idle"); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_full();
    test_rx_single();
    test_rx_overrun();
    test_glitch_decode();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
